// File: rtl/alu_arbiter_if.sv
// Request/result bundle shared by the two requesters, the arbiter and the result consumer.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_c;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res_c, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res_c, res_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one six-operation ALU with a one-entry result register.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int               SHW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH;

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_c_q, res_c_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] alu_c;
    logic [SHW-1:0]   shamt;
    logic             shift_oor;

    // Readies are held low during reset even though the result register is empty.
    always_comb begin
        can_accept = !res_valid_q || bus.res_ready;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (rst_n && can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        sel_a     = grant1 ? bus.req1_a  : bus.req0_a;
        sel_b     = grant1 ? bus.req1_b  : bus.req0_b;
        sel_op    = grant1 ? bus.req1_op : bus.req0_op;
        shamt     = sel_b[SHW-1:0];
        shift_oor = (sel_b >= WIDTH_V);
        alu_c     = '0;
        case (sel_op)
            3'b000:  alu_c = sel_a + sel_b;
            3'b001:  alu_c = sel_a - sel_b;
            3'b010:  alu_c = sel_a & sel_b;
            3'b011:  alu_c = sel_a | sel_b;
            3'b100:  alu_c = shift_oor ? '0 : (sel_a >> shamt);
            default: alu_c = shift_oor ? {WIDTH{sel_a[WIDTH-1]}}
                                       : WIDTH'($signed(sel_a) >>> shamt);
        endcase
    end

    // A grant in the same cycle as a drain overwrites the register, so no bubble.
    always_comb begin
        res_valid_d  = res_valid_q;
        res_c_d      = res_c_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        if (grant0 || grant1) begin
            res_valid_d  = 1'b1;
            res_c_d      = alu_c;
            res_id_d     = grant1;
            last_grant_d = grant1;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_c_q      <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            res_valid_q  <= res_valid_d;
            res_c_q      <= res_c_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_c      = res_c_q;
    assign bus.res_id     = res_id_q;
endmodule
